// File: rtl/mme_tile_sequencer.sv
// ---------------------------------------------------------------------------
// mme_tile_sequencer
//
// Splits C = A x B (A is MxK, B is KxN, C is MxN, all row-major) into
// SA_WIDTH x SA_WIDTH tiles and issues one tile command at a time to the
// DMA/MM datapath. The K loop runs innermost, so each output tile is built by
// KT consecutive commands: the first clears the accumulators (and optionally
// loads the existing C), the last writes the C tile back.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  job start pulse, honoured only when idle
//   m_dim_i/k_dim_i/n_dim_i  matrix dimensions in elements
//   a_addr_i/b_addr_i/c_addr_i  matrix base byte addresses
//   c_accum_i                accumulate into the existing C
//   tile_req_o / tile_ack_i  tile command valid / accepted
//   tile_a/b/c_addr_o        tile start byte addresses
//   tile_first_k_o           first K-step of an output tile
//   tile_load_c_o            first K-step with accumulate enabled
//   tile_last_k_o            last K-step of an output tile
//   tile_done_i              accepted tile has completed (pulse)
//   busy_o                   job in progress
//   done_o / err_o           sticky completion / illegal-shape flags
//   tile_cnt_o               completed tiles in the current job
// ---------------------------------------------------------------------------
module mme_tile_sequencer #(
    parameter int SA_WIDTH = 4,
    parameter int DW       = 32,
    parameter int DIM_W    = 8,
    parameter int AW       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DIM_W-1:0] m_dim_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic [AW-1:0]    b_addr_i,
    input  logic [AW-1:0]    c_addr_i,
    input  logic             c_accum_i,
    output logic             tile_req_o,
    input  logic             tile_ack_i,
    output logic [AW-1:0]    tile_a_addr_o,
    output logic [AW-1:0]    tile_b_addr_o,
    output logic [AW-1:0]    tile_c_addr_o,
    output logic             tile_first_k_o,
    output logic             tile_load_c_o,
    output logic             tile_last_k_o,
    input  logic             tile_done_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      tile_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_ISSUE,
        S_WAIT
    } state_e;

    localparam int               SA_LOG     = $clog2(SA_WIDTH);
    localparam logic [DIM_W-1:0] SA_MASK    = DIM_W'(SA_WIDTH - 1);
    localparam logic [AW-1:0]    SA_AW      = AW'(SA_WIDTH);
    localparam logic [AW-1:0]    ELEM_BYTES = AW'(DW / 8);

    state_e state_q, state_d;

    // Job configuration, captured at start so the inputs may change mid-job.
    logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [AW-1:0]    a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic             accum_q, accum_d;

    // Tile indices: row of C, column of C, K-step.
    logic [DIM_W-1:0] ti_q, ti_d, tj_q, tj_d, tk_q, tk_d;

    // Registered tile command fields.
    logic [AW-1:0]    tile_a_q, tile_a_d, tile_b_q, tile_b_d, tile_c_q, tile_c_d;
    logic             first_k_q, first_k_d, last_k_q, last_k_d, load_c_q, load_c_d;

    logic             done_q, done_d, err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;

    logic [DIM_W-1:0] mt, kt, nt;
    logic             ti_last, tj_last, tk_last;

    // A dimension is unusable if it is zero or not a whole number of tiles.
    function automatic logic dim_bad(input logic [DIM_W-1:0] d);
        return (d == '0) || ((d & SA_MASK) != '0);
    endfunction

    // base + (row_tile*SA*stride + col_tile*SA) * bytes_per_element, mod 2^AW.
    function automatic logic [AW-1:0] tile_addr(input logic [AW-1:0]    base,
                                                input logic [DIM_W-1:0] row_tile,
                                                input logic [DIM_W-1:0] stride,
                                                input logic [DIM_W-1:0] col_tile);
        logic [AW-1:0] elems;
        elems = AW'(row_tile) * SA_AW * AW'(stride) + AW'(col_tile) * SA_AW;
        return base + elems * ELEM_BYTES;
    endfunction

    assign mt      = m_q >> SA_LOG;
    assign kt      = k_q >> SA_LOG;
    assign nt      = n_q >> SA_LOG;
    assign ti_last = (ti_q == mt - DIM_W'(1));
    assign tj_last = (tj_q == nt - DIM_W'(1));
    assign tk_last = (tk_q == kt - DIM_W'(1));

    always_comb begin
        // NOTE: every next-state value defaults to its current value first,
        // so no branch below can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        n_d       = n_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        c_base_d  = c_base_q;
        accum_d   = accum_q;
        ti_d      = ti_q;
        tj_d      = tj_q;
        tk_d      = tk_q;
        tile_a_d  = tile_a_q;
        tile_b_d  = tile_b_q;
        tile_c_d  = tile_c_q;
        first_k_d = first_k_q;
        last_k_d  = last_k_q;
        load_c_d  = load_c_q;
        done_d    = done_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_d      = m_dim_i;
                    k_d      = k_dim_i;
                    n_d      = n_dim_i;
                    a_base_d = a_addr_i;
                    b_base_d = b_addr_i;
                    c_base_d = c_addr_i;
                    accum_d  = c_accum_i;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_CHECK;
                end
            end

            S_CHECK: begin
                if (dim_bad(m_q) || dim_bad(k_q) || dim_bad(n_q)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ti_d    = '0;
                    tj_d    = '0;
                    tk_d    = '0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                tile_a_d  = tile_addr(a_base_q, ti_q, k_q, tk_q);
                tile_b_d  = tile_addr(b_base_q, tk_q, n_q, tj_q);
                tile_c_d  = tile_addr(c_base_q, ti_q, n_q, tj_q);
                first_k_d = (tk_q == '0);
                last_k_d  = tk_last;
                load_c_d  = (tk_q == '0) && accum_q;
                state_d   = S_ISSUE;
            end

            S_ISSUE: begin
                if (tile_ack_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (tile_done_i) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_ADDR;
                    // K-step advances fastest, then the C column, then the C row.
                    if (!tk_last) begin
                        tk_d = tk_q + DIM_W'(1);
                    end else begin
                        tk_d = '0;
                        if (!tj_last) begin
                            tj_d = tj_q + DIM_W'(1);
                        end else begin
                            tj_d = '0;
                            if (!ti_last) begin
                                ti_d = ti_q + DIM_W'(1);
                            end else begin
                                ti_d    = '0;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others. Every register is
    // reset because reset must drive every output (including addresses) to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            accum_q   <= 1'b0;
            ti_q      <= '0;
            tj_q      <= '0;
            tk_q      <= '0;
            tile_a_q  <= '0;
            tile_b_q  <= '0;
            tile_c_q  <= '0;
            first_k_q <= 1'b0;
            last_k_q  <= 1'b0;
            load_c_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            k_q       <= k_d;
            n_q       <= n_d;
            a_base_q  <= a_base_d;
            b_base_q  <= b_base_d;
            c_base_q  <= c_base_d;
            accum_q   <= accum_d;
            ti_q      <= ti_d;
            tj_q      <= tj_d;
            tk_q      <= tk_d;
            tile_a_q  <= tile_a_d;
            tile_b_q  <= tile_b_d;
            tile_c_q  <= tile_c_d;
            first_k_q <= first_k_d;
            last_k_q  <= last_k_d;
            load_c_q  <= load_c_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tile_req_o     = (state_q == S_ISSUE);
    assign busy_o         = (state_q != S_IDLE);
    assign tile_a_addr_o  = tile_a_q;
    assign tile_b_addr_o  = tile_b_q;
    assign tile_c_addr_o  = tile_c_q;
    assign tile_first_k_o = first_k_q;
    assign tile_last_k_o  = last_k_q;
    assign tile_load_c_o  = load_c_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign tile_cnt_o     = cnt_q;

endmodule

// File: tb/tb_mme_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mme_tile_sequencer
//
// Drives directed and randomized jobs into mme_tile_sequencer. For each job
// the expected tile command list is built from the tiling rules with plain
// nested loops, then every issued command, handshake latency, counter value
// and completion flag is compared against it.
// ---------------------------------------------------------------------------
module tb_mme_tile_sequencer;

    localparam int SA = 4;
    localparam int EB = 4;   // bytes per 32-bit element

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  m_dim_i, k_dim_i, n_dim_i;
    logic [31:0] a_addr_i, b_addr_i, c_addr_i;
    logic        c_accum_i;
    logic        tile_req_o;
    logic        tile_ack_i;
    logic [31:0] tile_a_addr_o, tile_b_addr_o, tile_c_addr_o;
    logic        tile_first_k_o, tile_load_c_o, tile_last_k_o;
    logic        tile_done_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] tile_cnt_o;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        first_k;
        logic        last_k;
        logic        load_c;
    } tile_t;

    tile_t exp_q[$];
    int    n_asserts = 0;
    int    n_fail    = 0;

    always #5 clk = ~clk;

    mme_tile_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .m_dim_i       (m_dim_i),
        .k_dim_i       (k_dim_i),
        .n_dim_i       (n_dim_i),
        .a_addr_i      (a_addr_i),
        .b_addr_i      (b_addr_i),
        .c_addr_i      (c_addr_i),
        .c_accum_i     (c_accum_i),
        .tile_req_o    (tile_req_o),
        .tile_ack_i    (tile_ack_i),
        .tile_a_addr_o (tile_a_addr_o),
        .tile_b_addr_o (tile_b_addr_o),
        .tile_c_addr_o (tile_c_addr_o),
        .tile_first_k_o(tile_first_k_o),
        .tile_load_c_o (tile_load_c_o),
        .tile_last_k_o (tile_last_k_o),
        .tile_done_i   (tile_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .tile_cnt_o    (tile_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected command stream: C row tiles outermost, K-steps innermost.
    task automatic build_model(input int m, input int k, input int n,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input bit acc);
        tile_t t;
        exp_q.delete();
        for (int ti = 0; ti < m / SA; ti++)
            for (int tj = 0; tj < n / SA; tj++)
                for (int tk = 0; tk < k / SA; tk++) begin
                    t.a       = a + 32'((ti * SA * k + tk * SA) * EB);
                    t.b       = b + 32'((tk * SA * n + tj * SA) * EB);
                    t.c       = c + 32'((ti * SA * n + tj * SA) * EB);
                    t.first_k = (tk == 0);
                    t.last_k  = (tk == k / SA - 1);
                    t.load_c  = (tk == 0) && acc;
                    exp_q.push_back(t);
                end
    endtask

    task automatic check_fields(input string tag, input tile_t t);
        check({tag, ".a"},       tile_a_addr_o,  t.a);
        check({tag, ".b"},       tile_b_addr_o,  t.b);
        check({tag, ".c"},       tile_c_addr_o,  t.c);
        check({tag, ".first_k"}, tile_first_k_o, t.first_k);
        check({tag, ".last_k"},  tile_last_k_o,  t.last_k);
        check({tag, ".load_c"},  tile_load_c_o,  t.load_c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},    tile_req_o,     0);
        check({tag, ".busy"},   busy_o,         0);
        check({tag, ".done"},   done_o,         0);
        check({tag, ".err"},    err_o,          0);
        check({tag, ".cnt"},    tile_cnt_o,     0);
        check({tag, ".a"},      tile_a_addr_o,  0);
        check({tag, ".b"},      tile_b_addr_o,  0);
        check({tag, ".c"},      tile_c_addr_o,  0);
        check({tag, ".first"},  tile_first_k_o, 0);
        check({tag, ".last"},   tile_last_k_o,  0);
        check({tag, ".load_c"}, tile_load_c_o,  0);
    endtask

    // Runs one job. Inputs are driven and outputs sampled at negedges.
    // abort_tile >= 0 asserts rst while waiting for that tile to complete.
    task automatic run_job(input string name, input int m, input int k, input int n,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input bit acc, input int min_bp, input int max_bp,
                           input int max_lat, input bit strays, input int abort_tile);
        bit legal;
        int w, bp, lat;
        legal = (m > 0) && (k > 0) && (n > 0) && (m % SA == 0) && (k % SA == 0) && (n % SA == 0);
        build_model(m, k, n, a, b, c, acc);

        @(negedge clk);
        start_i   = 1'b1;
        m_dim_i   = 8'(m);
        k_dim_i   = 8'(k);
        n_dim_i   = 8'(n);
        a_addr_i  = a;
        b_addr_i  = b;
        c_addr_i  = c;
        c_accum_i = acc;
        @(negedge clk);
        // Scramble config inputs: the job must run from the latched copy.
        start_i   = 1'b0;
        m_dim_i   = 8'($urandom);
        k_dim_i   = 8'($urandom);
        n_dim_i   = 8'($urandom);
        a_addr_i  = $urandom;
        b_addr_i  = $urandom;
        c_addr_i  = $urandom;
        c_accum_i = 1'($urandom);
        check({name, ".start.busy"}, busy_o, 1);
        check({name, ".start.done"}, done_o, 0);
        check({name, ".start.err"},  err_o,  0);
        check({name, ".start.cnt"},  tile_cnt_o, 0);

        if (!legal) begin
            check({name, ".chk.req"}, tile_req_o, 0);
            @(negedge clk);
            check({name, ".ill.err"},  err_o,  1);
            check({name, ".ill.done"}, done_o, 1);
            check({name, ".ill.busy"}, busy_o, 0);
            check({name, ".ill.req"},  tile_req_o, 0);
            @(negedge clk);
            check({name, ".ill.req2"}, tile_req_o, 0);
            return;
        end

        foreach (exp_q[i]) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!tile_req_o && w < 20);
            check($sformatf("%s.t%0d.req", name, i), tile_req_o, 1);
            check($sformatf("%s.t%0d.req_latency", name, i), w, (i == 0) ? 2 : 1);
            check_fields($sformatf("%s.t%0d", name, i), exp_q[i]);

            bp = $urandom_range(min_bp, max_bp);
            if (strays && bp == 0) bp = 1;
            for (int j = 0; j < bp; j++) begin
                tile_ack_i  = 1'b0;
                tile_done_i = strays && (j == 0);
                @(negedge clk);
                tile_done_i = 1'b0;
                check($sformatf("%s.t%0d.bp%0d.req", name, i, j), tile_req_o, 1);
                check($sformatf("%s.t%0d.bp%0d.cnt", name, i, j), tile_cnt_o, i);
                check_fields($sformatf("%s.t%0d.bp%0d", name, i, j), exp_q[i]);
            end
            tile_ack_i = 1'b1;
            @(negedge clk);
            tile_ack_i = 1'b0;
            check($sformatf("%s.t%0d.req_drop", name, i), tile_req_o, 0);
            check($sformatf("%s.t%0d.wait_busy", name, i), busy_o, 1);

            if (i == abort_tile) begin
                #1 rst = 1'b1;
                #1 check_all_zero($sformatf("%s.t%0d.rst", name, i));
                #1 rst = 1'b0;
                return;
            end

            lat = $urandom_range(0, max_lat);
            if (strays && lat == 0) lat = 1;
            for (int j = 0; j < lat; j++) begin
                start_i = strays && (j == 0);
                @(negedge clk);
                start_i = 1'b0;
                check($sformatf("%s.t%0d.lat%0d.cnt", name, i, j), tile_cnt_o, i);
                check($sformatf("%s.t%0d.lat%0d.req", name, i, j), tile_req_o, 0);
                check($sformatf("%s.t%0d.lat%0d.busy", name, i, j), busy_o, 1);
            end
            tile_done_i = 1'b1;
            @(negedge clk);
            tile_done_i = 1'b0;
            check($sformatf("%s.t%0d.cnt", name, i), tile_cnt_o, i + 1);
            check($sformatf("%s.t%0d.done", name, i), done_o, (i == exp_q.size() - 1));
            check($sformatf("%s.t%0d.busy", name, i), busy_o, (i != exp_q.size() - 1));
        end
        check({name, ".end.err"}, err_o, 0);
    endtask

    initial begin
        int          m, k, n;
        logic [31:0] ra, rb, rc;
        int          dims[4] = '{4, 8, 12, 16};

        rst         = 1'b1;
        start_i     = 1'b0;
        m_dim_i     = '0;
        k_dim_i     = '0;
        n_dim_i     = '0;
        a_addr_i    = '0;
        b_addr_i    = '0;
        c_addr_i    = '0;
        c_accum_i   = 1'b0;
        tile_ack_i  = 1'b0;
        tile_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single tile.
        run_job("single", 4, 4, 4, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 0, 0, 1'b0, -1);

        // 8x8x8, zero-latency datapath.
        run_job("mm888", 8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 0, 0, 1'b0, -1);

        // Illegal shapes, then a legal job clears the error.
        run_job("ill_m6", 6, 4, 4, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 0, 0, 1'b0, -1);
        run_job("ill_k0", 4, 0, 4, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0, 0, 0, 1'b0, -1);
        run_job("after_ill", 4, 4, 4, 32'h4000, 32'h5000, 32'h6000, 1'b1, 0, 1, 1, 1'b0, -1);

        // Backpressure of 5 cycles per tile with accumulate.
        run_job("bp_acc", 4, 8, 4, 32'h1000, 32'h2000, 32'h3000, 1'b1, 5, 5, 2, 1'b0, -1);

        // Stray tile_done in ISSUE and stray start in WAIT.
        run_job("strays", 8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 1'b0, 1, 3, 3, 1'b1, -1);

        // Reset while waiting on tile 3, then a fresh job from (0,0,0).
        run_job("abort", 8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 1'b1, 0, 1, 1, 1'b0, 3);
        @(negedge clk);
        check_all_zero("after_abort");
        run_job("restart", 8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 1'b1, 0, 1, 1, 1'b0, -1);

        // Randomized jobs, including address wrap and occasional bad shapes.
        for (int r = 0; r < 16; r++) begin
            m  = dims[$urandom_range(0, 3)];
            k  = dims[$urandom_range(0, 3)];
            n  = dims[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) k = k + $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) n = 0;
            ra = $urandom;
            rb = $urandom;
            rc = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            run_job($sformatf("rnd%0d", r), m, k, n, ra, rb, rc, 1'($urandom),
                    0, 3, 3, 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mme_tile_sequencer.md
# mme_tile_sequencer

Tile-level sequencer for the next-generation matrix-multiply engine. It takes the general problem C = A×B, where A is M×K, B is K×N and C is M×N, in row-major memory, and splits it into SA_WIDTH×SA_WIDTH tiles. It then issues one tile command at a time to the DMA/MM datapath, which supports only a single square tile. The block sits between the APB configuration registers and the DMA engine. It adds rectangular shapes, K-loop accumulation and an optional accumulate-into-existing-C mode.

## Interface
- SA_WIDTH, default 4: systolic array width in PEs; tile edge in elements (power of two).
- DW, default 32: element width in bits; element byte size is DW/8.
- DIM_W, default 8: width of each dimension field.
- AW, default 32: byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- m_dim_i, k_dim_i, n_dim_i  in  DIM_W each  matrix dimensions in elements.
- a_addr_i, b_addr_i, c_addr_i  in  AW each  base byte addresses.
- c_accum_i  in  1  when 1, the first K-step of each output tile also loads the existing C.
- tile_req_o  out  1  tile command valid.
- tile_ack_i  in  1  tile command accepted by the datapath.
- tile_a_addr_o, tile_b_addr_o, tile_c_addr_o  out  AW each  tile start addresses.
- tile_first_k_o  out  1  first K-step: datapath clears its accumulators.
- tile_load_c_o  out  1  equals tile_first_k_o AND latched c_accum.
- tile_last_k_o  out  1  last K-step: datapath writes the C tile back.
- tile_done_i  in  1  one-cycle pulse: the accepted tile has completed.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  sticky completion flag; cleared by an accepted start.
- err_o  out  1  sticky illegal-dimension flag; cleared by an accepted start.
- tile_cnt_o  out  32  number of completed tiles in the current job.

## Operation
- States: IDLE, CHECK, ADDR, ISSUE, WAIT.
- IDLE + start_i:
  - latch all config inputs;
  - clear done_o, err_o and tile_cnt_o;
  - go to CHECK.
- start_i is ignored outside IDLE.
- CHECK, error case: if any dimension is 0 or not a multiple of SA_WIDTH, set err_o=1 and done_o=1, then go to IDLE.
- CHECK, legal case: zero the tile indices ti, tj, tk, then go to ADDR.
- Tile counts: MT=M/SA_WIDTH, KT=K/SA_WIDTH, NT=N/SA_WIDTH.
- ADDR: register the three addresses and the flags, then go to ISSUE. Let E=DW/8.
  - A = a_base + (ti·SA_WIDTH·K + tk·SA_WIDTH)·E
  - B = b_base + (tk·SA_WIDTH·N + tj·SA_WIDTH)·E
  - C = c_base + (ti·SA_WIDTH·N + tj·SA_WIDTH)·E
  - Address arithmetic wraps modulo 2^AW.
  - first_k = (tk==0); last_k = (tk==KT-1). With KT=1, both flags are 1.
- ISSUE: hold tile_req_o=1 with all tile fields stable until tile_ack_i=1, then go to WAIT.
- WAIT: on tile_done_i, increment tile_cnt_o, then advance the indices:
  - tk advances fastest, then tj, then ti.
  - If (ti,tj,tk) was (MT-1,NT-1,KT-1), set done_o=1 and go to IDLE; otherwise go to ADDR.
- tile_done_i is ignored outside WAIT. tile_ack_i is ignored while tile_req_o=0.
- rst, at any time including mid-job:
  - state goes to IDLE;
  - every output goes to 0, including tile_req_o, busy_o, done_o, err_o, tile_cnt_o, all addresses and all flags;
  - the job is abandoned.

## Timing
- Edge numbering: start_i is sampled at edge E0, and the state is CHECK after E0.
- Legal job: ADDR after E1, ISSUE after E2, so tile_req_o first rises 3 cycles after start.
- Illegal job: err_o=done_o=1 and busy_o=0 after E1.
- Handshake: if tile_ack_i is already high when tile_req_o rises, the transfer takes 1 cycle. tile_req_o drops on the edge after the handshake.
- Tile-to-tile gap: tile_done_i at edge Et puts the state in ADDR after Et, and tile_req_o rises after Et+1.
- Job completion: the final tile_done_i at edge Et gives done_o=1 and busy_o=0 after Et.
- A job of T tiles with zero datapath latency takes 2 + 2T cycles plus the handshake cycles.

## Test plan
- Single tile: M=K=N=4, a=0x1000, b=0x2000, c=0x3000, c_accum=0.
  - Required: one request with A=0x1000, B=0x2000, C=0x3000, first_k=last_k=1, load_c=0.
  - After tile_done_i: done_o=1, tile_cnt_o=1.
- 8×8×8 with the same bases:
  - Required: 8 requests in the order (0,0,0), (0,0,1), (0,1,0) … (1,1,1).
  - Tile (0,0,1): A=0x1010, B=0x2080, C=0x3000, last_k=1.
  - Tile (1,1,1): A=0x1090, B=0x2090, C=0x3090.
  - Final tile_cnt_o=8.
- Illegal shapes: M=6, then K=0.
  - Required: err_o=done_o=1 two cycles after start, tile_req_o never asserted.
  - A following legal start clears err_o.
- Backpressure plus accumulate: M=4, K=8, N=4, c_accum=1; hold tile_ack_i low for 5 cycles.
  - Required: tile_req_o and all tile fields stay stable for those 5 cycles.
  - Tile 0: load_c=1, first_k=1. Tile 1: load_c=0, last_k=1.
- Stray pulses: tile_done_i in ISSUE and start_i in WAIT.
  - Required: both ignored; tile_cnt_o and the indices are unchanged.
- Reset mid-job: assert rst in WAIT of tile 3 of the 8×8×8 job.
  - Required: all outputs are 0 in the same cycle.
  - A new start restarts from (0,0,0).
